// File: rtl/bpress_gen.sv
// Button-press generator: turns request pulses into timed active-low presses, queueing overlapping requests.
// Optional contact-bounce emulation before each press is enabled by defining BPRESS_BOUNCE_EN.
module bpress_gen #(
  parameter int HOLD_CYCLES   = 7,
  parameter int GAP_CYCLES    = 3,
  parameter int PEND_W        = 3,
  parameter int BOUNCE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pulse_in,
  output logic              button_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 1 || PEND_W < 1) begin : g_bad_cfg
    $error("bpress_gen: HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES and PEND_W must be >= 1");
  end

`ifdef BPRESS_BOUNCE_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_GAP    = 2'd2,
    S_BOUNCE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;
`endif

  localparam logic [15:0]       HOLD_LD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0]       GAP_LD   = 16'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

`ifdef BPRESS_BOUNCE_EN
  localparam logic [15:0] BNC_LD   = 16'(BOUNCE_CYCLES - 1);
  localparam state_t      START_ST = S_BOUNCE;
  localparam logic [15:0] START_LD = BNC_LD;
`else
  localparam state_t      START_ST = S_HOLD;
  localparam logic [15:0] START_LD = HOLD_LD;
`endif

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                btn_q, btn_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;

  logic avail;
  logic take;
  logic pend_zero;
  logic enq;
  logic deq;

  assign pend_zero = (pend_q == '0);
  assign avail     = pulse_in | ~pend_zero;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (avail) begin
          take    = 1'b1;
          state_d = START_ST;
          cnt_d   = START_LD;
          btn_d   = 1'b0;
        end
      end
`ifdef BPRESS_BOUNCE_EN
      S_BOUNCE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          btn_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
          btn_d = ~btn_q;
        end
      end
`endif
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
          btn_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        // Last gap cycle chains straight into the next press, no idle cycle.
        if (cnt_q == '0) begin
          if (avail) begin
            take    = 1'b1;
            state_d = START_ST;
            cnt_d   = START_LD;
            btn_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            btn_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        btn_d   = 1'b1;
      end
    endcase
  end

  // A consumed request comes from the queue when one is waiting, else from pulse_in.
  assign deq = take & ~pend_zero;
  assign enq = pulse_in & ~(take & pend_zero);

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (enq && !deq) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (deq && !enq) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b1;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign button_out = btn_q;
  assign busy       = (state_q != S_IDLE);
  assign pending    = pend_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_bpress_gen.sv
// Directed bench for bpress_gen: single press, queued presses, saturation, chained press, reset abort.
module tb_bpress_gen;

  localparam int H = 7;
  localparam int G = 3;
`ifdef BPRESS_BOUNCE_EN
  localparam int B = 4;
`else
  localparam int B = 0;
`endif
  localparam int P = B + H + G;

  logic       CLK;
  logic       RST;
  logic       pulse_a, pulse_b;
  logic       btn_a, busy_a, ovf_a;
  logic [2:0] pend_a;
  logic       btn_b, busy_b, ovf_b;
  logic [1:0] pend_b;

  int n_chk;
  int n_fail;
  int lows;

  bpress_gen dut_a (
    .CLK(CLK), .RST(RST), .pulse_in(pulse_a),
    .button_out(btn_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
  );

  bpress_gen #(.PEND_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .pulse_in(pulse_b),
    .button_out(btn_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Expected button level t cycles after the edge that started a press.
  function automatic int exp_btn(input int t);
    if (t < B) return t % 2;
    else if (t < B + H) return 0;
    else return 1;
  endfunction

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    RST     = 1'b0;
    pulse_a = 1'b0;
    pulse_b = 1'b0;
    @(negedge CLK);
    tick();
    tick();
    chk("rst_btn", btn_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_pend", pend_a, 0);
    chk("rst_ovf", ovf_a, 0);
    RST = 1'b1;
    tick();

    // single press
    for (int e = 0; e <= P; e++) begin
      pulse_a = (e == 0);
      tick();
      pulse_a = 1'b0;
      chk("single_btn", btn_a, (e < P) ? exp_btn(e) : 1);
      chk("single_busy", busy_a, (e < P) ? 1 : 0);
      chk("single_pend", pend_a, 0);
    end

    // three requests queue up and replay back to back
    for (int e = 0; e <= 3 * P; e++) begin
      pulse_a = (e < 3);
      tick();
      pulse_a = 1'b0;
      chk("queue_btn", btn_a, (e < 3 * P) ? exp_btn(e % P) : 1);
      chk("queue_busy", busy_a, (e < 3 * P) ? 1 : 0);
      chk("queue_pend", pend_a, (e < P) ? ((e < 2) ? e : 2) : ((e < 2 * P) ? 1 : 0));
    end
    tick();

    // request on the final gap edge is taken directly
    for (int e = 0; e <= 2 * P; e++) begin
      pulse_a = (e == 0) || (e == P);
      tick();
      pulse_a = 1'b0;
      chk("chain_btn", btn_a, (e < 2 * P) ? exp_btn(e % P) : 1);
      chk("chain_busy", busy_a, (e < 2 * P) ? 1 : 0);
      chk("chain_pend", pend_a, 0);
    end
    tick();

    // reset during a hold with two requests queued
    for (int e = 0; e <= B + 3; e++) begin
      pulse_a = (e < 3);
      RST = (e == B + 3) ? 1'b0 : 1'b1;
      tick();
      pulse_a = 1'b0;
      if (e == B + 2) chk("abort_pend_before", pend_a, 2);
    end
    chk("abort_btn", btn_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_pend", pend_a, 0);
    RST = 1'b1;
    for (int e = 0; e < 2 * P; e++) begin
      tick();
      chk("abort_idle_btn", btn_a, 1);
      chk("abort_idle_busy", busy_a, 0);
    end

    // narrow queue saturates and drops the fifth request
    lows = 0;
    for (int e = 0; e <= 4 * P; e++) begin
      pulse_b = (e < 5);
      tick();
      pulse_b = 1'b0;
      if (btn_b == 1'b0) lows++;
      chk("sat_pend", pend_b,
          (e <= 3) ? e : ((e < P) ? 3 : ((e < 2 * P) ? 2 : ((e < 3 * P) ? 1 : 0))));
      chk("sat_ovf", ovf_b, (e >= 4) ? 1 : 0);
      chk("sat_busy", busy_b, (e < 4 * P) ? 1 : 0);
    end
    chk("sat_low_cycles", lows, 4 * (H + (B + 1) / 2));
    for (int e = 0; e < P; e++) tick();
    chk("sat_ovf_sticky", ovf_b, 1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("sat_ovf_cleared", ovf_b, 0);
    chk("sat_pend_cleared", pend_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bpress_gen.md
# bpress_gen

Button-press generator: the transmit-side counterpart of the button shaper. It turns single-cycle request pulses into clean, timed, active-low button waveforms that a shaper input or an external button line accepts. Requests that arrive while a press is in progress are counted and replayed in order as back-to-back presses. It sits between the control/test logic that issues press requests and any consumer of raw active-low button levels.

## Interface
- HOLD_CYCLES, 7: cycles `button_out` is held low per press; must be ≥1.
- GAP_CYCLES, 3: cycles `button_out` is held high after each press; must be ≥1.
- PEND_W, 3: width of the pending-request counter; it saturates at 2^PEND_W−1.
- BOUNCE_CYCLES, 4: length of the emulated contact-bounce burst; used only with `BPRESS_BOUNCE_EN`; must be ≥1.

Ports:
- CLK  in  1: clock; all logic updates on the rising edge.
- RST  in  1: reset, synchronous, active-low.
- pulse_in  in  1: press request, sampled high on a rising edge; each high cycle counts as one request.
- button_out  out  1: generated button level, active-low; idles at 1.
- busy  out  1: high whenever the FSM is not in IDLE.
- pending  out  PEND_W: number of queued requests not yet started.
- overflow  out  1: sticky flag; set when a request is dropped because the queue is at saturation.

## Operation
- Request available: `avail = pulse_in | (pending != 0)`.
- FSM states: IDLE, BOUNCE (present only with the macro), HOLD, GAP. One 16-bit down-counter times each state.
- IDLE → HOLD (or BOUNCE) on an edge where `avail` = 1. That edge consumes one request.
- BOUNCE → HOLD after BOUNCE_CYCLES cycles.
- HOLD → GAP after HOLD_CYCLES cycles.
- GAP, last cycle: if `avail` = 1, go directly to HOLD (or BOUNCE) and consume a request. Otherwise go to IDLE.
- Consume rule: the request is taken from `pulse_in` if `pending` = 0, else from the queue.
- Pending update each edge: `pending + enq − deq`, where:
  - `enq` = `pulse_in` not consumed directly;
  - `deq` = a consumed queued request.
  - Simultaneous enq and deq leaves `pending` unchanged.
- Saturation: when `pending` = 2^PEND_W−1, an enq with no deq is dropped and sets `overflow`. `overflow` clears only on reset.
- `button_out` is registered:
  - 0 in HOLD;
  - 1 in GAP and IDLE;
  - in BOUNCE, alternates 0,1,0,… starting with 0.
- `busy` = (state != IDLE), registered with the state.

## Timing
- Reset values (RST low at an edge): `button_out`=1, `busy`=0, `pending`=0, `overflow`=0, state IDLE, counter 0.
- Reset mid-operation aborts the press. `button_out` is 1 after that edge and queued requests are discarded.
- Latency: `pulse_in` high at edge k while IDLE with `pending`=0 gives `button_out`=0 and `busy`=1 after edge k.
- Press length: `button_out` is low for exactly HOLD_CYCLES cycles, then high for exactly GAP_CYCLES cycles.
- Back-to-back presses repeat with a period of HOLD_CYCLES+GAP_CYCLES cycles, plus BOUNCE_CYCLES when bounce is enabled, with no IDLE cycle between presses.
- `busy` falls after the last GAP edge if nothing is available.
- A `pulse_in` on the final GAP edge is consumed directly: the next press starts with no gap extension, and `pending` is not incremented.
- `pulse_in` held high for n cycles = n requests.

## Configuration
- `BPRESS_BOUNCE_EN` defined:
  - each press is preceded by the BOUNCE state: BOUNCE_CYCLES cycles of `button_out` toggling, starting at 0;
  - `busy` is asserted throughout BOUNCE.
- `BPRESS_BOUNCE_EN` not defined:
  - BOUNCE state and its logic are not compiled;
  - BOUNCE_CYCLES is ignored;
  - presses go straight to HOLD.

## Test plan
- Defaults, macro off. One `pulse_in` at edge 0 → `button_out`=0 after edges 0–6, `button_out`=1 after edge 7; `busy`=1 for 10 cycles; `pending` stays 0.
- Three consecutive `pulse_in` cycles (edges 0–2) → `pending` reads 1 then 2 → three presses at 10-cycle period (low at edges 0, 10, 20) → `pending` 2→1→0; `busy` drops after edge 29.
- PEND_W=2. Five pulses on edges 0–4 → first starts directly; `pending` reaches 3; fifth sets `overflow`=1 → exactly four presses emitted; `overflow` remains 1 until reset.
- `pulse_in` at the last GAP edge of a press → next HOLD begins the following cycle; `pending` stays 0.
- RST low at edge 3 of a HOLD with `pending`=2 → after that edge `button_out`=1, `busy`=0, `pending`=0; no further presses.
- Macro on, BOUNCE_CYCLES=4. One pulse → `button_out` sequence 0,1,0,1, then 0 for 7 cycles, then 1 for 3 cycles; `busy` high for 14 cycles.
